// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester main-RAM arbiter: FSM encoding,
// requester indices and default bus widths.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 4;

    localparam int REQ_CPU = 0;
    localparam int REQ_DMA = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone request always wins,
// a tie goes to the requester named by ptr.
module mem_arbiter_rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       valid
);

    // One-hot winner selection
    always_comb begin
        gnt   = 2'b00;
        valid = |req;
        if (req[REQ_CPU] && (!req[REQ_DMA] || !ptr)) begin
            gnt[REQ_CPU] = 1'b1;
        end else if (req[REQ_DMA]) begin
            gnt[REQ_DMA] = 1'b1;
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the single-port main RAM: CPU data port (0) and
// display/IO DMA port (1), one fixed-latency transaction in flight at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              ptr_r, ptr_s;
    logic [1:0]        grant_r, grant_s;
    logic              busy_r, busy_s;
    logic              mem_en_r, mem_en_s;
    logic              mem_we_r, mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic [DATA_W-1:0] rdata_r, rdata_s;
    logic              ack0_r, ack0_s;
    logic              ack1_r, ack1_s;
    logic [1:0]        pick_gnt_s;
    logic              pick_valid_s;

    mem_arbiter_rr_pick2 u_pick (
        .req   ({req1, req0}),
        .ptr   (ptr_r),
        .gnt   (pick_gnt_s),
        .valid (pick_valid_s)
    );

    // Next-state and next-output logic; outputs are the registered copies
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        ptr_s       = ptr_r;
        grant_s     = grant_r;
        busy_s      = busy_r;
        mem_en_s    = 1'b0;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        rdata_s     = rdata_r;
        ack0_s      = 1'b0;
        ack1_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_s  = ST_ACCESS;
                    grant_s  = pick_gnt_s;
                    busy_s   = 1'b1;
                    mem_en_s = 1'b1;
                    if (pick_gnt_s[REQ_DMA]) begin
                        mem_we_s    = we1;
                        mem_addr_s  = addr1;
                        mem_wdata_s = wdata1;
                    end else begin
                        mem_we_s    = we0;
                        mem_addr_s  = addr0;
                        mem_wdata_s = wdata0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                cnt_s   = CNT_W'(MEM_LAT);
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // Read data is only valid in the final wait cycle
                if (cnt_r <= CNT_W'(1)) begin
                    cnt_s   = {CNT_W{1'b0}};
                    rdata_s = mem_rdata;
                    ack0_s  = grant_r[REQ_CPU];
                    ack1_s  = grant_r[REQ_DMA];
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_DONE: begin
                ptr_s   = grant_r[REQ_CPU];
                grant_s = 2'b00;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = 2'b00;
                busy_s  = 1'b0;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers, cleared asynchronously on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            ptr_r       <= 1'b0;
            grant_r     <= 2'b00;
            busy_r      <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            rdata_r     <= {DATA_W{1'b0}};
            ack0_r      <= 1'b0;
            ack1_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            ptr_r       <= ptr_s;
            grant_r     <= grant_s;
            busy_r      <= busy_s;
            mem_en_r    <= mem_en_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            rdata_r     <= rdata_s;
            ack0_r      <= ack0_s;
            ack1_r      <= ack1_s;
        end
    end

    assign ack0      = ack0_r;
    assign ack1      = ack1_r;
    assign rdata     = rdata_r;
    assign grant     = grant_r;
    assign busy      = busy_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule
